stage_id: RTL and testbench

//  Instruction Decode stage, directly downstream of the IF stage. Decodes IFout_Inst
//  (MIPS subset), reads a 32x32 register file written back by WB, and detects load-use hazards.

---
 rtl/stage_id.sv | 219 +++++++++++++++++++++
 tb/tb_stage_id.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// Instruction Decode stage for a MIPS subset pipeline.
// Decodes the fetched instruction, reads the 32x32 register file (written by WB),
// detects load-use hazards and registers everything into the ID/EX boundary.
module stage_id #(
   parameter int REGFILE_BYPASS = 1
) (
   input  logic        Clk,
   input  logic        Clrn,
   input  logic [31:0] IFout_PC,
   input  logic [31:0] IFout_PC4,
   input  logic [31:0] IFout_Inst,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_WriteReg,
   input  logic [31:0] WB_WriteData,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_Rt,
   input  logic        MEM_PCSrc,
   output logic        ID_Stall,
   output logic [31:0] IDout_PC,
   output logic [31:0] IDout_PC4,
   output logic [31:0] IDout_RD1,
   output logic [31:0] IDout_RD2,
   output logic [31:0] IDout_Imm32,
   output logic [31:0] IDout_Jtarg,
   output logic [4:0]  IDout_Rs,
   output logic [4:0]  IDout_Rt,
   output logic [4:0]  IDout_Rd,
   output logic        IDout_RegWrite,
   output logic        IDout_MemRead,
   output logic        IDout_MemWrite,
   output logic        IDout_MemtoReg,
   output logic        IDout_ALUSrc,
   output logic        IDout_RegDst,
   output logic        IDout_Branch,
   output logic        IDout_Jump,
   output logic [2:0]  IDout_ALUCtrl
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;

   logic [31:0] reg_file [32];
   logic [31:0] rd1;
   logic [31:0] rd2;

   logic        dec_reg_write;
   logic        dec_mem_read;
   logic        dec_mem_write;
   logic        dec_memto_reg;
   logic        dec_alu_src;
   logic        dec_reg_dst;
   logic        dec_branch;
   logic        dec_jump;
   logic [2:0]  dec_alu_ctrl;
   logic        sign_ext;
   logic [31:0] imm32;
   logic [31:0] jtarg;

   logic        uses_rt;
   logic        load_use;
   logic        bubble;

   assign op    = IFout_Inst[31:26];
   assign funct = IFout_Inst[5:0];
   assign rs    = IFout_Inst[25:21];
   assign rt    = IFout_Inst[20:16];
   assign rd    = IFout_Inst[15:11];

   // Register file write port; r0 is never written so it always reads as zero
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int i = 0; i < 32; i++) begin
            reg_file[i] <= '0;
         end
      end else if (WB_RegWrite && (WB_WriteReg != 5'd0)) begin
         reg_file[WB_WriteReg] <= WB_WriteData;
      end
   end

   // Asynchronous read ports with optional write-through of the WB value
   always_comb begin
      rd1 = reg_file[rs];
      rd2 = reg_file[rt];
      if ((REGFILE_BYPASS != 0) && WB_RegWrite && (WB_WriteReg == rs)) begin
         rd1 = WB_WriteData;
      end
      if ((REGFILE_BYPASS != 0) && WB_RegWrite && (WB_WriteReg == rt)) begin
         rd2 = WB_WriteData;
      end
      if (rs == 5'd0) begin
         rd1 = '0;
      end
      if (rt == 5'd0) begin
         rd2 = '0;
      end
   end

   // Main decoder: anything not recognised becomes a NOP with all controls low
   always_comb begin
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_memto_reg = 1'b0;
      dec_alu_src   = 1'b0;
      dec_reg_dst   = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
      dec_alu_ctrl  = 3'b000;
      sign_ext      = 1'b1;
      case (op)
         6'h00: begin
            case (funct)
               6'h20: begin dec_alu_ctrl = 3'b010; dec_reg_write = 1'b1; dec_reg_dst = 1'b1; end
               6'h22: begin dec_alu_ctrl = 3'b110; dec_reg_write = 1'b1; dec_reg_dst = 1'b1; end
               6'h24: begin dec_alu_ctrl = 3'b000; dec_reg_write = 1'b1; dec_reg_dst = 1'b1; end
               6'h25: begin dec_alu_ctrl = 3'b001; dec_reg_write = 1'b1; dec_reg_dst = 1'b1; end
               6'h2A: begin dec_alu_ctrl = 3'b111; dec_reg_write = 1'b1; dec_reg_dst = 1'b1; end
               default: ;
            endcase
         end
         6'h23: begin
            dec_alu_ctrl  = 3'b010;
            dec_alu_src   = 1'b1;
            dec_mem_read  = 1'b1;
            dec_memto_reg = 1'b1;
            dec_reg_write = 1'b1;
         end
         6'h2B: begin
            dec_alu_ctrl  = 3'b010;
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         6'h04: begin
            dec_alu_ctrl = 3'b110;
            dec_branch   = 1'b1;
         end
         6'h08: begin
            dec_alu_ctrl  = 3'b010;
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
         end
         6'h0C: begin
            dec_alu_ctrl  = 3'b000;
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            sign_ext      = 1'b0;
         end
         6'h0D: begin
            dec_alu_ctrl  = 3'b001;
            dec_alu_src   = 1'b1;
            dec_reg_write = 1'b1;
            sign_ext      = 1'b0;
         end
         6'h02: begin
            dec_jump = 1'b1;
         end
         default: ;
      endcase
   end

   assign imm32 = sign_ext ? {{16{IFout_Inst[15]}}, IFout_Inst[15:0]} : {16'h0000, IFout_Inst[15:0]};
   assign jtarg = {IFout_PC4[31:28], IFout_Inst[25:0], 2'b00};

   // Load-use detection: rt only counts for instructions that actually read it
   always_comb begin
      uses_rt  = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                 ((EX_Rt == rs) || ((EX_Rt == rt) && uses_rt));
      bubble   = load_use || MEM_PCSrc;
      ID_Stall = load_use && !MEM_PCSrc && Clrn;
   end

   // ID/EX boundary register; controls are squashed on a stall or a flush
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         IDout_PC       <= '0;
         IDout_PC4      <= '0;
         IDout_RD1      <= '0;
         IDout_RD2      <= '0;
         IDout_Imm32    <= '0;
         IDout_Jtarg    <= '0;
         IDout_Rs       <= '0;
         IDout_Rt       <= '0;
         IDout_Rd       <= '0;
         IDout_RegWrite <= 1'b0;
         IDout_MemRead  <= 1'b0;
         IDout_MemWrite <= 1'b0;
         IDout_MemtoReg <= 1'b0;
         IDout_ALUSrc   <= 1'b0;
         IDout_RegDst   <= 1'b0;
         IDout_Branch   <= 1'b0;
         IDout_Jump     <= 1'b0;
         IDout_ALUCtrl  <= 3'b000;
      end else begin
         IDout_PC       <= IFout_PC;
         IDout_PC4      <= IFout_PC4;
         IDout_RD1      <= rd1;
         IDout_RD2      <= rd2;
         IDout_Imm32    <= imm32;
         IDout_Jtarg    <= jtarg;
         IDout_Rs       <= rs;
         IDout_Rt       <= rt;
         IDout_Rd       <= rd;
         IDout_RegWrite <= dec_reg_write && !bubble;
         IDout_MemRead  <= dec_mem_read  && !bubble;
         IDout_MemWrite <= dec_mem_write && !bubble;
         IDout_MemtoReg <= dec_memto_reg && !bubble;
         IDout_ALUSrc   <= dec_alu_src   && !bubble;
         IDout_RegDst   <= dec_reg_dst   && !bubble;
         IDout_Branch   <= dec_branch    && !bubble;
         IDout_Jump     <= dec_jump      && !bubble;
         IDout_ALUCtrl  <= bubble ? 3'b000 : dec_alu_ctrl;
      end
   end

endmodule

// File: tb/tb_stage_id.sv
// Scoreboard bench for stage_id: stimulus pushes expected results, a monitor pops and checks.
module tb_stage_id;

   logic        Clk;
   logic        Clrn;
   logic [31:0] IFout_PC;
   logic [31:0] IFout_PC4;
   logic [31:0] IFout_Inst;
   logic        WB_RegWrite;
   logic [4:0]  WB_WriteReg;
   logic [31:0] WB_WriteData;
   logic        EX_MemRead;
   logic [4:0]  EX_Rt;
   logic        MEM_PCSrc;

   logic        ID_Stall;
   logic [31:0] IDout_PC, IDout_PC4, IDout_RD1, IDout_RD2, IDout_Imm32, IDout_Jtarg;
   logic [4:0]  IDout_Rs, IDout_Rt, IDout_Rd;
   logic        IDout_RegWrite, IDout_MemRead, IDout_MemWrite, IDout_MemtoReg;
   logic        IDout_ALUSrc, IDout_RegDst, IDout_Branch, IDout_Jump;
   logic [2:0]  IDout_ALUCtrl;

   logic        n_Stall;
   logic [31:0] n_PC, n_PC4, n_RD1, n_RD2, n_Imm32, n_Jtarg;
   logic [4:0]  n_Rs, n_Rt, n_Rd;
   logic        n_RegWrite, n_MemRead, n_MemWrite, n_MemtoReg;
   logic        n_ALUSrc, n_RegDst, n_Branch, n_Jump;
   logic [2:0]  n_ALUCtrl;

   typedef struct {
      string       name;
      logic        expStall;
      logic        checkData;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] jtarg;
      logic [14:0] regs;
      logic [7:0]  ctrl;
      logic [2:0]  alu;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] rd1n;
      logic [31:0] rd2n;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mregs [32];
   logic [31:0] pcNext;
   int          assertCount = 0;
   int          failCount   = 0;

   stage_id #(.REGFILE_BYPASS(1)) dut (
      .Clk(Clk), .Clrn(Clrn), .IFout_PC(IFout_PC), .IFout_PC4(IFout_PC4), .IFout_Inst(IFout_Inst),
      .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .MEM_PCSrc(MEM_PCSrc), .ID_Stall(ID_Stall),
      .IDout_PC(IDout_PC), .IDout_PC4(IDout_PC4), .IDout_RD1(IDout_RD1), .IDout_RD2(IDout_RD2),
      .IDout_Imm32(IDout_Imm32), .IDout_Jtarg(IDout_Jtarg), .IDout_Rs(IDout_Rs), .IDout_Rt(IDout_Rt),
      .IDout_Rd(IDout_Rd), .IDout_RegWrite(IDout_RegWrite), .IDout_MemRead(IDout_MemRead),
      .IDout_MemWrite(IDout_MemWrite), .IDout_MemtoReg(IDout_MemtoReg), .IDout_ALUSrc(IDout_ALUSrc),
      .IDout_RegDst(IDout_RegDst), .IDout_Branch(IDout_Branch), .IDout_Jump(IDout_Jump),
      .IDout_ALUCtrl(IDout_ALUCtrl)
   );

   stage_id #(.REGFILE_BYPASS(0)) dutNoBypass (
      .Clk(Clk), .Clrn(Clrn), .IFout_PC(IFout_PC), .IFout_PC4(IFout_PC4), .IFout_Inst(IFout_Inst),
      .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
      .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .MEM_PCSrc(MEM_PCSrc), .ID_Stall(n_Stall),
      .IDout_PC(n_PC), .IDout_PC4(n_PC4), .IDout_RD1(n_RD1), .IDout_RD2(n_RD2),
      .IDout_Imm32(n_Imm32), .IDout_Jtarg(n_Jtarg), .IDout_Rs(n_Rs), .IDout_Rt(n_Rt),
      .IDout_Rd(n_Rd), .IDout_RegWrite(n_RegWrite), .IDout_MemRead(n_MemRead),
      .IDout_MemWrite(n_MemWrite), .IDout_MemtoReg(n_MemtoReg), .IDout_ALUSrc(n_ALUSrc),
      .IDout_RegDst(n_RegDst), .IDout_Branch(n_Branch), .IDout_Jump(n_Jump),
      .IDout_ALUCtrl(n_ALUCtrl)
   );

   // Free-running clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {6'h00, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one instruction for a cycle and queue what the DUT must show for it
   task automatic applyStimulus(input string name, input logic [31:0] inst,
                                input logic wbEn, input logic [4:0] wbReg, input logic [31:0] wbData,
                                input logic exMemRead, input logic [4:0] exRt, input logic pcSrc,
                                input logic expStall, input logic [7:0] expCtrl, input logic [2:0] expAlu,
                                input logic [31:0] expImm);
      exp_t e;
      logic [4:0] rs;
      logic [4:0] rt;
      @(posedge Clk);
      #1;
      IFout_PC     = pcNext;
      IFout_PC4    = pcNext + 32'd4;
      IFout_Inst   = inst;
      WB_RegWrite  = wbEn;
      WB_WriteReg  = wbReg;
      WB_WriteData = wbData;
      EX_MemRead   = exMemRead;
      EX_Rt        = exRt;
      MEM_PCSrc    = pcSrc;
      rs = inst[25:21];
      rt = inst[20:16];
      e.name      = name;
      e.expStall  = expStall;
      e.checkData = !expStall && !pcSrc;
      e.pc        = pcNext;
      e.imm       = expImm;
      e.jtarg     = {IFout_PC4[31:28], inst[25:0], 2'b00};
      e.regs      = inst[25:11];
      e.ctrl      = expCtrl;
      e.alu       = expAlu;
      e.rd1n      = (rs == 5'd0) ? 32'd0 : mregs[rs];
      e.rd2n      = (rt == 5'd0) ? 32'd0 : mregs[rt];
      e.rd1       = (wbEn && rs != 5'd0 && wbReg == rs) ? wbData : e.rd1n;
      e.rd2       = (wbEn && rt != 5'd0 && wbReg == rt) ? wbData : e.rd2n;
      expQ.push_back(e);
      if (wbEn && wbReg != 5'd0) mregs[wbReg] = wbData;
      pcNext = pcNext + 32'd4;
   endtask

   // Return inputs to a quiet idle state
   task automatic idleInputs();
      @(posedge Clk);
      #1;
      IFout_Inst  = 32'd0;
      WB_RegWrite = 1'b0;
      EX_MemRead  = 1'b0;
      MEM_PCSrc   = 1'b0;
   endtask

   // Monitor: stall is checked mid-cycle for the current item, registered outputs one cycle later
   initial begin
      exp_t prev;
      exp_t cur;
      logic havePrev;
      havePrev = 1'b0;
      forever begin
         @(negedge Clk);
         if (havePrev) begin
            checkOutput({prev.name, " ctrl"}, {24'd0, IDout_RegWrite, IDout_MemRead, IDout_MemWrite,
                        IDout_MemtoReg, IDout_ALUSrc, IDout_RegDst, IDout_Branch, IDout_Jump}, {24'd0, prev.ctrl});
            checkOutput({prev.name, " aluctrl"}, {29'd0, IDout_ALUCtrl}, {29'd0, prev.alu});
            checkOutput({prev.name, " nobyp ctrl"}, {24'd0, n_RegWrite, n_MemRead, n_MemWrite,
                        n_MemtoReg, n_ALUSrc, n_RegDst, n_Branch, n_Jump, n_ALUCtrl} >> 3, {24'd0, prev.ctrl});
            checkOutput({prev.name, " pc"}, IDout_PC, prev.pc);
            checkOutput({prev.name, " pc4"}, IDout_PC4, prev.pc + 32'd4);
            checkOutput({prev.name, " imm32"}, IDout_Imm32, prev.imm);
            checkOutput({prev.name, " jtarg"}, IDout_Jtarg, prev.jtarg);
            checkOutput({prev.name, " rs/rt/rd"}, {17'd0, IDout_Rs, IDout_Rt, IDout_Rd}, {17'd0, prev.regs});
            if (prev.checkData) begin
               checkOutput({prev.name, " rd1"}, IDout_RD1, prev.rd1);
               checkOutput({prev.name, " rd2"}, IDout_RD2, prev.rd2);
               checkOutput({prev.name, " nobyp rd1"}, n_RD1, prev.rd1n);
               checkOutput({prev.name, " nobyp rd2"}, n_RD2, prev.rd2n);
            end
         end
         if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            checkOutput({cur.name, " stall"}, {31'd0, ID_Stall}, {31'd0, cur.expStall});
            checkOutput({cur.name, " nobyp stall"}, {31'd0, n_Stall}, {31'd0, cur.expStall});
            prev = cur;
            havePrev = 1'b1;
         end else begin
            havePrev = 1'b0;
         end
      end
   end

   // Directed sequence
   initial begin
      int waitCycles;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      pcNext       = 32'h0000_1000;
      Clrn         = 1'b0;
      IFout_PC     = 32'hDEAD_BEE0;
      IFout_PC4    = 32'hDEAD_BEE4;
      IFout_Inst   = rType(5'd8, 5'd8, 5'd1, 6'h20);
      WB_RegWrite  = 1'b1;
      WB_WriteReg  = 5'd7;
      WB_WriteData = 32'hAAAA_5555;
      EX_MemRead   = 1'b1;
      EX_Rt        = 5'd8;
      MEM_PCSrc    = 1'b0;

      // Reset holds everything low even with a hazard on the inputs
      #1;
      checkOutput("reset stall", {31'd0, ID_Stall}, 32'd0);
      repeat (2) @(posedge Clk);
      #1;
      checkOutput("reset pc", IDout_PC | IDout_PC4, 32'd0);
      checkOutput("reset data", IDout_RD1 | IDout_RD2 | IDout_Imm32 | IDout_Jtarg, 32'd0);
      checkOutput("reset fields", {17'd0, IDout_Rs, IDout_Rt, IDout_Rd}, 32'd0);
      checkOutput("reset ctrl", {21'd0, IDout_RegWrite, IDout_MemRead, IDout_MemWrite, IDout_MemtoReg,
                  IDout_ALUSrc, IDout_RegDst, IDout_Branch, IDout_Jump, IDout_ALUCtrl}, 32'd0);
      WB_RegWrite = 1'b0;
      EX_MemRead  = 1'b0;
      IFout_Inst  = 32'd0;
      Clrn        = 1'b1;

      $display("[TB] register file reads zero after reset");
      for (int i = 1; i < 32; i++) begin
         applyStimulus("rf zero", rType(5'(i), 5'(i), 5'd1, 6'h20), 1'b0, 5'd0, 32'd0,
                       1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_0820);
      end

      $display("[TB] same-cycle writeback and r0");
      applyStimulus("wb r5 bypass", rType(5'd5, 5'd5, 5'd3, 6'h20), 1'b1, 5'd5, 32'h0000_1234,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_1820);
      applyStimulus("read r5", rType(5'd5, 5'd5, 5'd3, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_1820);
      applyStimulus("wb r0", rType(5'd0, 5'd0, 5'd1, 6'h20), 1'b1, 5'd0, 32'hFFFF_FFFF,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_0820);
      applyStimulus("read r0", rType(5'd0, 5'd0, 5'd1, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_0820);
      applyStimulus("wb r2", 32'd0, 1'b1, 5'd2, 32'h0000_0010,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 3'b000, 32'd0);
      applyStimulus("wb r8", 32'd0, 1'b1, 5'd8, 32'h0000_0055,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 3'b000, 32'd0);

      $display("[TB] load-use hazards and flush");
      applyStimulus("stall rs", rType(5'd8, 5'd2, 5'd9, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd8, 1'b0, 1'b1, 8'h00, 3'b000, 32'h0000_4820);
      applyStimulus("addi no stall", iType(6'h08, 5'd2, 5'd9, 16'h0001), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd9, 1'b0, 1'b0, 8'h88, 3'b010, 32'h0000_0001);
      applyStimulus("stall rt R", rType(5'd2, 5'd9, 5'd1, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd9, 1'b0, 1'b1, 8'h00, 3'b000, 32'h0000_0820);
      applyStimulus("stall rt sw", iType(6'h2B, 5'd2, 5'd9, 16'h0004), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd9, 1'b0, 1'b1, 8'h00, 3'b000, 32'h0000_0004);
      applyStimulus("lw rt no stall", iType(6'h23, 5'd2, 5'd4, 16'h0000), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd4, 1'b0, 1'b0, 8'hD8, 3'b010, 32'h0000_0000);
      applyStimulus("ex rt0 no stall", rType(5'd0, 5'd0, 5'd1, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_0820);
      applyStimulus("no load no stall", rType(5'd8, 5'd2, 5'd9, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd8, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_4820);
      applyStimulus("flush beats stall", rType(5'd8, 5'd2, 5'd9, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b1, 5'd8, 1'b1, 1'b0, 8'h00, 3'b000, 32'h0000_4820);
      applyStimulus("flush lw", iType(6'h23, 5'd2, 5'd4, 16'hFFF8), 1'b1, 5'd6, 32'h0000_0666,
                    1'b0, 5'd0, 1'b1, 1'b0, 8'h00, 3'b000, 32'hFFFF_FFF8);

      $display("[TB] decode sweep");
      applyStimulus("addi neg", iType(6'h08, 5'd2, 5'd4, 16'hFFFC), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h88, 3'b010, 32'hFFFF_FFFC);
      applyStimulus("ori zext", iType(6'h0D, 5'd6, 5'd4, 16'hFFFC), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h88, 3'b001, 32'h0000_FFFC);
      applyStimulus("andi zext", iType(6'h0C, 5'd2, 5'd4, 16'h8001), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h88, 3'b000, 32'h0000_8001);
      applyStimulus("lw", iType(6'h23, 5'd2, 5'd4, 16'hFFF8), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'hD8, 3'b010, 32'hFFFF_FFF8);
      applyStimulus("sw", iType(6'h2B, 5'd2, 5'd8, 16'h0010), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h28, 3'b010, 32'h0000_0010);
      applyStimulus("beq", iType(6'h04, 5'd2, 5'd8, 16'hFFFF), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h02, 3'b110, 32'hFFFF_FFFF);
      applyStimulus("sub", rType(5'd2, 5'd8, 5'd3, 6'h22), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b110, 32'h0000_1822);
      applyStimulus("and", rType(5'd2, 5'd8, 5'd3, 6'h24), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b000, 32'h0000_1824);
      applyStimulus("or", rType(5'd2, 5'd8, 5'd3, 6'h25), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b001, 32'h0000_1825);
      applyStimulus("slt", rType(5'd2, 5'd8, 5'd3, 6'h2A), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b111, 32'h0000_182A);
      applyStimulus("R bad funct", rType(5'd2, 5'd8, 5'd3, 6'h21), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 3'b000, 32'h0000_1821);
      applyStimulus("op 3F nop", iType(6'h3F, 5'd2, 5'd4, 16'h8000), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 3'b000, 32'hFFFF_8000);
      pcNext = 32'h0040_0000;
      applyStimulus("j", 32'h0800_0010, 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h01, 3'b000, 32'h0000_0010);
      idleInputs();

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 100) begin
         @(posedge Clk);
         waitCycles++;
      end
      checkOutput("scoreboard drained", expQ.size(), 32'd0);
      repeat (2) @(posedge Clk);

      // Reset asserted mid-cycle clears outputs and register file immediately
      $display("[TB] asynchronous reset mid-operation");
      #1;
      IFout_PC   = 32'h0000_0100;
      IFout_PC4  = 32'h0000_0104;
      IFout_Inst = rType(5'd5, 5'd8, 5'd3, 6'h20);
      @(posedge Clk);
      #1;
      checkOutput("pre-reset rd1", IDout_RD1, 32'h0000_1234);
      #2;
      Clrn = 1'b0;
      #1;
      checkOutput("async reset pc", IDout_PC, 32'd0);
      checkOutput("async reset rd", IDout_RD1 | IDout_RD2, 32'd0);
      checkOutput("async reset ctrl", {29'd0, IDout_RegWrite, IDout_RegDst, IDout_ALUCtrl[1]}, 32'd0);
      @(posedge Clk);
      #1;
      Clrn = 1'b1;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      applyStimulus("rf cleared", rType(5'd5, 5'd8, 5'd3, 6'h20), 1'b0, 5'd0, 32'd0,
                    1'b0, 5'd0, 1'b0, 1'b0, 8'h84, 3'b010, 32'h0000_1820);
      idleInputs();
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 100) begin
         @(posedge Clk);
         waitCycles++;
      end
      checkOutput("final drain", expQ.size(), 32'd0);
      repeat (2) @(posedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
